// File: rtl/gun_position_ctrl.sv
`timescale 1ns/1ps
// gun_position_ctrl: joystick-driven light-gun cursor with two independent
// accelerating axes stepped on rising edges of the 4 ms timebase.

// gun_axis: one saturating 6-bit position with an IDLE/SLOW/FAST step FSM.
module gun_axis #(
  parameter int unsigned DIV_SLOW    = 3,
  parameter int unsigned DIV_FAST    = 1,
  parameter int unsigned ACCEL_STEPS = 8,
  parameter int unsigned CENTER      = 32
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       recenter,
  input  logic       dec,
  input  logic       inc,
  output logic [5:0] pos,
  output logic       change
);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  localparam logic [2:0] SLOW_MAX  = 3'(DIV_SLOW - 1);
  localparam logic [2:0] FAST_MAX  = 3'(DIV_FAST - 1);
  localparam logic [3:0] ACCEL     = 4'(ACCEL_STEPS);
  localparam logic [5:0] CENTER_P  = 6'(CENTER);

  state_t     state, state_n;
  logic [2:0] div, div_n;
  logic [3:0] cnt, cnt_n;
  logic       dir_inc, dir_inc_n;
  logic [5:0] pos_n;
  logic [5:0] stepped;
  logic [3:0] cnt_inc;
  logic       active;

  assign active  = dec ^ inc;
  assign cnt_inc = cnt + 4'd1;
  assign change  = (pos_n != pos);

  // Saturating one-step move in the requested direction (inc wins when active).
  always_comb begin
    stepped = pos;
    if (inc) begin
      if (pos != 6'd63) stepped = pos + 6'd1;
    end else begin
      if (pos != 6'd0) stepped = pos - 6'd1;
    end
  end

  // State, counters and position registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div     <= '0;
      cnt     <= '0;
      dir_inc <= 1'b0;
      pos     <= CENTER_P;
    end else begin
      state   <= state_n;
      div     <= div_n;
      cnt     <= cnt_n;
      dir_inc <= dir_inc_n;
      pos     <= pos_n;
    end
  end

  // Next-state: recenter beats disable beats tick handling.
  always_comb begin
    state_n   = state;
    div_n     = div;
    cnt_n     = cnt;
    dir_inc_n = dir_inc;
    pos_n     = pos;
    if (recenter) begin
      state_n = IDLE;
      div_n   = '0;
      cnt_n   = '0;
      pos_n   = CENTER_P;
    end else if (!enable) begin
      state_n = IDLE;
      div_n   = '0;
      cnt_n   = '0;
    end else if (tick) begin
      if (!active) begin
        state_n = IDLE;
        div_n   = '0;
        cnt_n   = '0;
      end else if (state == IDLE || inc != dir_inc) begin
        // Fresh press or reversal: immediate step, restart acceleration.
        pos_n     = stepped;
        dir_inc_n = inc;
        div_n     = '0;
        cnt_n     = 4'd1;
        state_n   = SLOW;
      end else if (state == SLOW) begin
        if (div == SLOW_MAX) begin
          pos_n = stepped;
          div_n = '0;
          cnt_n = cnt_inc;
          if (cnt_inc >= ACCEL) state_n = FAST;
        end else begin
          div_n = div + 3'd1;
        end
      end else begin
        if (div == FAST_MAX) begin
          pos_n = stepped;
          div_n = '0;
        end else begin
          div_n = div + 3'd1;
        end
      end
    end
  end

endmodule

module gun_position_ctrl #(
  parameter int unsigned DIV_SLOW    = 3,
  parameter int unsigned DIV_FAST    = 1,
  parameter int unsigned ACCEL_STEPS = 8,
  parameter int unsigned CENTER      = 32
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick_4ms,
  input  logic       enable,
  input  logic       recenter,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  output logic [5:0] gun_h,
  output logic [5:0] gun_v,
  output logic       moved
);

  logic tick_prev;
  logic tick;
  logic change_h;
  logic change_v;

  assign tick = tick_4ms & ~tick_prev;

  // Edge sampler resets high so a level already high at release is not a tick.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tick_prev <= 1'b1;
    else          tick_prev <= tick_4ms;
  end

  // moved mirrors a position update in the same edge it lands.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) moved <= 1'b0;
    else          moved <= change_h | change_v;
  end

  gun_axis #(
    .DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST),
    .ACCEL_STEPS(ACCEL_STEPS), .CENTER(CENTER)
  ) u_axis_h (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick), .enable(enable),
    .recenter(recenter), .dec(left), .inc(right), .pos(gun_h), .change(change_h)
  );

  gun_axis #(
    .DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST),
    .ACCEL_STEPS(ACCEL_STEPS), .CENTER(CENTER)
  ) u_axis_v (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick), .enable(enable),
    .recenter(recenter), .dec(up), .inc(down), .pos(gun_v), .change(change_v)
  );

endmodule

// File: tb/tb_gun_position_ctrl.sv
`timescale 1ns/1ps
// Directed bench for gun_position_ctrl: vector table plus multi-cycle sequences.
module tb_gun_position_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_4ms = 1'b0;
  logic       enable = 1'b1;
  logic       recenter = 1'b0;
  logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic [5:0] gun_h, gun_v;
  logic       moved;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         l, r, u, d, en, rc, tk;
    logic [5:0] eh, ev;
    bit         em;
  } vec_t;

  vec_t vecs[$];

  gun_position_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick_4ms(tick_4ms),
    .enable(enable), .recenter(recenter),
    .left(left), .right(right), .up(up), .down(down),
    .gun_h(gun_h), .gun_v(gun_v), .moved(moved)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit l, r, u, d, en, rc, tk,
                              input int eh, ev, input bit em);
    vec_t v;
    v.l = l; v.r = r; v.u = u; v.d = d; v.en = en; v.rc = rc; v.tk = tk;
    v.eh = 6'(eh); v.ev = 6'(ev); v.em = em;
    vecs.push_back(v);
  endfunction

  task automatic do_tick();
    @(negedge clk_sys);
    tick_4ms = 1'b1;
    @(negedge clk_sys);
    tick_4ms = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk_sys);
    left = v.l; right = v.r; up = v.u; down = v.d;
    enable = v.en; recenter = v.rc; tick_4ms = v.tk;
    @(negedge clk_sys);
    tick_4ms = 1'b0; recenter = 1'b0;
    check($sformatf("vec%0d_gun_h", idx), gun_h, v.eh);
    check($sformatf("vec%0d_gun_v", idx), gun_v, v.ev);
    check($sformatf("vec%0d_moved", idx), moved, v.em);
    @(negedge clk_sys);
    check($sformatf("vec%0d_moved_drop", idx), moved, 0);
  endtask

  initial begin
    int exp_r[25] = '{33,33,33,34,34,34,35,35,35,36,36,36,37,37,37,
                      38,38,38,39,39,39,40,41,42,43};
    int n;

    //   l r u d en rc tk  h   v  moved
    add(0,1,0,0,1, 0,1, 33, 32, 1);   // first press steps immediately
    add(0,0,0,0,1, 0,1, 33, 32, 0);   // release -> IDLE
    add(0,0,0,0,1, 1,0, 32, 32, 1);   // recenter alone
    add(0,1,0,1,1, 0,1, 33, 33, 1);   // both axes together
    add(0,0,0,0,1, 0,1, 33, 33, 0);
    add(0,0,0,0,1, 1,0, 32, 32, 1);
    for (int i = 0; i < 10; i++) add(1,1,0,0,1, 0,1, 32, 32, 0); // cancel
    for (int i = 0; i < 25; i++)
      add(0,1,0,0,1, 0,1, exp_r[i], 32, (i == 0) || (exp_r[i] != exp_r[i-1]));
    add(1,0,0,0,1, 0,0, 43, 32, 0);   // direction change between ticks: no effect
    add(1,0,0,0,1, 0,1, 42, 32, 1);   // reversal from FAST: immediate step
    add(1,0,0,0,1, 0,1, 42, 32, 0);
    add(1,0,0,0,1, 0,1, 42, 32, 0);
    add(1,0,0,0,1, 0,1, 41, 32, 1);   // SLOW again: third tick after reversal
    add(1,0,0,0,1, 1,1, 32, 32, 1);   // recenter beats tick
    add(1,0,0,0,1, 0,1, 31, 32, 1);   // IDLE after recenter: immediate step
    add(0,0,0,0,1, 0,1, 31, 32, 0);
    for (int i = 0; i < 5; i++) add(0,0,0,1,0, 0,1, 31, 32, 0); // disabled
    add(0,0,0,1,0, 1,0, 32, 32, 1);   // recenter works while disabled
    add(0,0,0,1,1, 0,1, 32, 33, 1);
    add(0,0,0,0,1, 0,1, 32, 33, 0);

    // Reset state
    reset_n = 1'b0;
    #12;
    check("reset_gun_h", gun_h, 32);
    check("reset_gun_v", gun_v, 32);
    check("reset_moved", moved, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Hold left from 32 down to 1 (8 SLOW steps over 22 ticks, then 1/tick)
    left = 1'b1; right = 1'b0; up = 1'b0; down = 1'b0; enable = 1'b1;
    n = 0;
    while (gun_h != 6'd1 && n < 80) begin
      do_tick();
      n++;
    end
    check("ticks_to_h1", n, 45);
    for (int i = 0; i < 10; i++) begin
      do_tick();
      check($sformatf("clamp%0d_gun_h", i), gun_h, 0);
      check($sformatf("clamp%0d_moved", i), moved, (i == 0) ? 1 : 0);
    end

    // Reset mid-FAST on the vertical axis
    @(negedge clk_sys);
    left = 1'b0; recenter = 1'b1;
    @(negedge clk_sys);
    recenter = 1'b0; down = 1'b1;
    for (int i = 0; i < 25; i++) do_tick();
    check("prefast_gun_v", gun_v, 43);
    check("prefast_moved", moved, 1);
    @(negedge clk_sys);
    tick_4ms = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async_rst_gun_v", gun_v, 32);
    check("async_rst_moved", moved, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;            // tick_4ms still high through release
    @(negedge clk_sys);
    check("post_rst_gun_v", gun_v, 32);
    check("post_rst_moved", moved, 0);
    tick_4ms = 1'b0;
    do_tick();
    check("post_rst_idle_step", gun_v, 33);
    check("post_rst_idle_moved", moved, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gun_position_ctrl.md
GUN_POSITION_CTRL -- requirements
Module: gun_position_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DIV_SLOW, 3: ticks per step in SLOW state.
- DIV_FAST, 1: ticks per step in FAST state.
- ACCEL_STEPS, 8: SLOW steps taken before entering FAST.
- CENTER, 32: position loaded on reset and on recenter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_sys, in, 1: system clock (12 MHz); the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- tick_4ms, in, 1: 4 ms timebase level from the williams2 cnt_4ms_o output, synchronous to clk_sys.
- enable, in, 1: high allows movement; low freezes positions (for example during ROM download).
- recenter, in, 1: synchronous one-cycle request to centre both axes.
- left, right, up, down, in, 1 each: joystick directions, active high.
- gun_h, out, 6: horizontal gun position, registered.
- gun_v, out, 6: vertical gun position, registered.
- moved, out, 1: one-cycle pulse when either position changes.

Function
REQ-003 The block SHALL detect a tick as tick_4ms=1 with its previous-cycle sample=0; only rising edges count.
REQ-004 The block SHALL update all state and outputs on the clk_sys edge that samples the tick rising edge, giving a latency of 1 clock from tick_4ms rising to the new gun_h/gun_v.
REQ-005 Each axis SHALL run an independent, identical FSM: horizontal uses dec=left and inc=right; vertical uses dec=up and inc=down.
REQ-006 Axis direction SHALL be decoded as follows: exactly one of dec/inc high gives an active direction; neither or both high gives none, so opposing inputs cancel.
REQ-007 The axis FSM states SHALL be IDLE, SLOW and FAST, with internal registers: tick divider (3 bits), step count (4 bits) and latched direction.
REQ-008 In IDLE, on a tick with an active direction, the axis SHALL:
- step 1 in that direction immediately;
- latch the direction;
- clear the divider;
- set step count to 1;
- go to SLOW.
REQ-009 In SLOW, on each tick with an unchanged active direction, the divider SHALL increment. When the divider reaches DIV_SLOW-1, the axis SHALL step, clear the divider and increment step count. When step count reaches ACCEL_STEPS, the axis SHALL go to FAST.
REQ-010 In FAST, the axis SHALL step each time the divider reaches DIV_FAST-1; with DIV_FAST=1 it steps on every tick.
REQ-011 In SLOW or FAST, a tick with no active direction SHALL send the axis to IDLE with no step and divider and step count cleared.
REQ-012 In SLOW or FAST, a tick whose active direction differs from the latched direction SHALL be handled as a fresh IDLE press (REQ-008): immediate step in the new direction, then SLOW.
REQ-013 Position arithmetic SHALL be 6-bit unsigned and saturating: a dec step at 0 holds 0 and an inc step at 63 holds 63. Wrap-around SHALL never occur, and the FSM SHALL still advance while clamped.
REQ-014 Direction inputs SHALL be sampled only on tick cycles; changes between ticks SHALL have no effect.
REQ-015 recenter=1 SHALL load CENTER into both axes, send both FSMs to IDLE and clear the dividers and step counts. recenter SHALL take priority over a tick in the same cycle, and moved SHALL pulse if either position changed.
REQ-016 enable=0 SHALL cause ticks to be ignored, hold both FSMs in IDLE with counters cleared, and hold the positions; recenter SHALL still function.
REQ-017 moved SHALL be 1 for exactly the cycle after any change in gun_h or gun_v, and 0 otherwise, including when a step is clamped.
REQ-018 The two axes SHALL be fully independent: simultaneous ticks, presses and accelerations on both axes SHALL each follow REQ-008 to REQ-013.

Reset
REQ-019 reset_n=0 SHALL asynchronously set gun_h=CENTER, gun_v=CENTER, moved=0, both FSMs to IDLE, all counters to 0 and the tick edge sampler to 1, so that no spurious tick occurs after release.
REQ-020 Reset asserted mid-motion SHALL abort the motion immediately. The first tick after reset_n rises SHALL be treated as from IDLE.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, then hold right for 1 tick -> gun_h=33 one clock after the tick edge, moved pulses once, gun_v=32.
- Hold right for 25 ticks from 32 -> steps on ticks 1, 4, 7, …, 22 (8 SLOW steps), then every tick; gun_h=43 after tick 25.
- Hold left from gun_h=1 for 10 ticks -> gun_h=0 and stays 0; moved pulses only on the first transition.
- Hold left and right together for 10 ticks -> gun_h unchanged at 32, moved never pulses.
- Moving in FAST, reverse to left -> immediate 1 step left, then 2-tick gap (SLOW); recenter on the same cycle as a tick -> both axes =32, FSM IDLE.
- Toggle enable=0 while holding down for 5 ticks -> gun_v unchanged. Assert reset_n=0 mid-FAST -> gun_v=32 asynchronously, with no step on the first post-reset clock.
